// File: rtl/ocp_tree_router.sv
// ---------------------------------------------------------------------------
// ocp_tree_router
//   Routes one OCP-style master to NUM_SLAVES slaves. The slave is selected
//   by the top SEL_W address bits. The command is latched in IDLE and
//   presented to the selected slave from the following cycle. A watchdog per
//   REQ/RESP phase turns a hung slave into an ERR response. The active link,
//   the FSM state and a saturating error count are exported for debug.
//
//   Ports
//     clk, rst_n               clock, asynchronous active-low reset
//     m_MCmd/m_MAddr/m_MData   master request (cmd 1 WR, 2 RD, else idle)
//     m_SCmdAccept             one-cycle accept pulse to the master
//     m_SResp/m_SData          response (0 NULL, 1 DVA, 3 ERR), valid in DONE
//     s_MCmd                   per-slave cmd, slave i on bits [3i+2:3i]
//     s_MAddr/s_MData          latched address/data broadcast to all slaves
//     s_SCmdAccept             per-slave accept
//     s_SData/s_SResp          per-slave read data and response
//     active_link              slave index of the latest routed transaction
//     link_state               FSM state (IDLE 0, REQ 1, ACK 2, RESP 3, DONE 4)
//     err_cnt                  decode/timeout/slave-ERR events, saturates at 255
// ---------------------------------------------------------------------------
module ocp_tree_router #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int SEL_W      = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   m_MCmd,
  input  logic [ADDR_W-1:0]            m_MAddr,
  input  logic [DATA_W-1:0]            m_MData,
  output logic                         m_SCmdAccept,
  output logic [DATA_W-1:0]            m_SData,
  output logic [1:0]                   m_SResp,
  output logic [3*NUM_SLAVES-1:0]      s_MCmd,
  output logic [ADDR_W-1:0]            s_MAddr,
  output logic [DATA_W-1:0]            s_MData,
  input  logic [NUM_SLAVES-1:0]        s_SCmdAccept,
  input  logic [DATA_W*NUM_SLAVES-1:0] s_SData,
  input  logic [2*NUM_SLAVES-1:0]      s_SResp,
  output logic [SEL_W-1:0]             active_link,
  output logic [2:0]                   link_state,
  output logic [7:0]                   err_cnt
);

  localparam logic [2:0] CMD_WR    = 3'd1;
  localparam logic [2:0] CMD_RD    = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  localparam logic [SEL_W:0] NUM_SLV_L = (SEL_W+1)'(NUM_SLAVES);
  localparam int             WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACK  = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              state;
  state_t              state_nxt;

  logic [2:0]          cmd_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [SEL_W-1:0]    sel_p0;
  logic                err_p0;
  logic [1:0]          resp_p1;
  logic [DATA_W-1:0]   rdata_p1;
  logic [WD_W-1:0]     wd_cnt;

  logic                m_cmd_valid;
  logic [SEL_W-1:0]    sel_in;
  logic                sel_ok;
  logic                acc_sel;
  logic [1:0]          resp_sel;
  logic [DATA_W-1:0]   rdata_sel;
  logic                wd_exp;
  logic                dec_err;
  logic                req_to;
  logic                resp_to;
  logic                slv_err;
  logic                err_evt;

  assign m_cmd_valid = (m_MCmd == CMD_WR) || (m_MCmd == CMD_RD);
  assign sel_in      = m_MAddr[ADDR_W-1 -: SEL_W];
  assign sel_ok      = ({1'b0, sel_in} < NUM_SLV_L);
  assign wd_exp      = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  // Selected-slave view; an out-of-range select leaves these at 0 and is
  // never consulted because decode errors bypass REQ/RESP.
  always_comb begin
    acc_sel   = 1'b0;
    resp_sel  = RESP_NULL;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_p0 == SEL_W'(i)) begin
        acc_sel   = s_SCmdAccept[i];
        resp_sel  = s_SResp[2*i +: 2];
        rdata_sel = s_SData[DATA_W*i +: DATA_W];
      end
    end
  end

  assign dec_err = (state == ST_IDLE) && m_cmd_valid && !sel_ok;
  assign req_to  = (state == ST_REQ)  && !acc_sel && wd_exp;
  assign resp_to = (state == ST_RESP) && (resp_sel == RESP_NULL) && wd_exp;
  assign slv_err = (state == ST_RESP) && (resp_sel == RESP_ERR);
  assign err_evt = dec_err || req_to || resp_to || slv_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (m_cmd_valid) state_nxt = sel_ok ? ST_REQ : ST_ACK;
      end
      ST_REQ: begin
        if (acc_sel || wd_exp) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        // Writes are posted: no response phase even when err is flagged.
        if (cmd_p0 == CMD_RD) state_nxt = err_p0 ? ST_DONE : ST_RESP;
        else                  state_nxt = ST_IDLE;
      end
      ST_RESP: begin
        if ((resp_sel != RESP_NULL) || wd_exp) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: command latch in IDLE; p1: response register loaded on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_p0      <= '0;
      addr_p0     <= '0;
      wdata_p0    <= '0;
      sel_p0      <= '0;
      err_p0      <= 1'b0;
      resp_p1     <= RESP_NULL;
      rdata_p1    <= '0;
      active_link <= '0;
      err_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_cmd_valid) begin
            cmd_p0   <= m_MCmd;
            addr_p0  <= m_MAddr;
            wdata_p0 <= m_MData;
            sel_p0   <= sel_in;
            err_p0   <= !sel_ok;
            if (sel_ok) active_link <= sel_in;
          end
        end
        ST_REQ: begin
          if (req_to) err_p0 <= 1'b1;
        end
        ST_ACK: begin
          if ((cmd_p0 == CMD_RD) && err_p0) begin
            resp_p1  <= RESP_ERR;
            rdata_p1 <= '0;
          end
        end
        ST_RESP: begin
          if (resp_sel != RESP_NULL) begin
            resp_p1  <= resp_sel;
            rdata_p1 <= rdata_sel;
          end else if (wd_exp) begin
            resp_p1  <= RESP_ERR;
            rdata_p1 <= '0;
          end
        end
        ST_DONE: begin
          resp_p1  <= RESP_NULL;
          rdata_p1 <= '0;
        end
        default: ;
      endcase
      if (err_evt) err_cnt <= sat_inc8(err_cnt);
    end
  end

  // Watchdog: held at 0 outside REQ/RESP so every phase entry starts from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   wd_cnt <= '0;
    else if ((state == ST_REQ) || (state == ST_RESP)) wd_cnt <= wd_cnt + 1'b1;
    else                                          wd_cnt <= '0;
  end

  always_comb begin
    s_MCmd = '0;
    if (state == ST_REQ) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_p0 == SEL_W'(i)) s_MCmd[3*i +: 3] = cmd_p0;
      end
    end
  end

  assign s_MAddr      = addr_p0;
  assign s_MData      = wdata_p0;
  assign m_SCmdAccept = (state == ST_ACK);
  assign m_SResp      = (state == ST_DONE) ? resp_p1  : RESP_NULL;
  assign m_SData      = (state == ST_DONE) ? rdata_p1 : '0;
  assign link_state   = state;

endmodule

// File: tb/tb_ocp_tree_router.sv
// ---------------------------------------------------------------------------
// tb_ocp_tree_router
//   Directed bench for ocp_tree_router. Instance A uses the default
//   parameters; instance B uses NUM_SLAVES=3, SEL_W=2, TIMEOUT=4.
//   Inputs change 1 ns after the rising edge, outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_ocp_tree_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: NUM_SLAVES=2, SEL_W=1, TIMEOUT=255
  logic        a_rst_n;
  logic [2:0]  a_m_MCmd;
  logic [7:0]  a_m_MAddr;
  logic [7:0]  a_m_MData;
  logic        a_m_SCmdAccept;
  logic [7:0]  a_m_SData;
  logic [1:0]  a_m_SResp;
  logic [5:0]  a_s_MCmd;
  logic [7:0]  a_s_MAddr;
  logic [7:0]  a_s_MData;
  logic [1:0]  a_s_SCmdAccept;
  logic [15:0] a_s_SData;
  logic [3:0]  a_s_SResp;
  logic [0:0]  a_active_link;
  logic [2:0]  a_link_state;
  logic [7:0]  a_err_cnt;

  // Instance B: NUM_SLAVES=3, SEL_W=2, TIMEOUT=4
  logic        b_rst_n;
  logic [2:0]  b_m_MCmd;
  logic [7:0]  b_m_MAddr;
  logic [7:0]  b_m_MData;
  logic        b_m_SCmdAccept;
  logic [7:0]  b_m_SData;
  logic [1:0]  b_m_SResp;
  logic [8:0]  b_s_MCmd;
  logic [7:0]  b_s_MAddr;
  logic [7:0]  b_s_MData;
  logic [2:0]  b_s_SCmdAccept;
  logic [23:0] b_s_SData;
  logic [5:0]  b_s_SResp;
  logic [1:0]  b_active_link;
  logic [2:0]  b_link_state;
  logic [7:0]  b_err_cnt;

  ocp_tree_router u_dut_a (
    .clk          (clk),
    .rst_n        (a_rst_n),
    .m_MCmd       (a_m_MCmd),
    .m_MAddr      (a_m_MAddr),
    .m_MData      (a_m_MData),
    .m_SCmdAccept (a_m_SCmdAccept),
    .m_SData      (a_m_SData),
    .m_SResp      (a_m_SResp),
    .s_MCmd       (a_s_MCmd),
    .s_MAddr      (a_s_MAddr),
    .s_MData      (a_s_MData),
    .s_SCmdAccept (a_s_SCmdAccept),
    .s_SData      (a_s_SData),
    .s_SResp      (a_s_SResp),
    .active_link  (a_active_link),
    .link_state   (a_link_state),
    .err_cnt      (a_err_cnt)
  );

  ocp_tree_router #(
    .NUM_SLAVES (3),
    .ADDR_W     (8),
    .DATA_W     (8),
    .SEL_W      (2),
    .TIMEOUT    (4)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (b_rst_n),
    .m_MCmd       (b_m_MCmd),
    .m_MAddr      (b_m_MAddr),
    .m_MData      (b_m_MData),
    .m_SCmdAccept (b_m_SCmdAccept),
    .m_SData      (b_m_SData),
    .m_SResp      (b_m_SResp),
    .s_MCmd       (b_s_MCmd),
    .s_MAddr      (b_s_MAddr),
    .s_MData      (b_s_MData),
    .s_SCmdAccept (b_s_SCmdAccept),
    .s_SData      (b_s_SData),
    .s_SResp      (b_s_SResp),
    .active_link  (b_active_link),
    .link_state   (b_link_state),
    .err_cnt      (b_err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_m_MCmd = 3'd0; a_m_MAddr = 8'h00; a_m_MData = 8'h00;
    a_s_SCmdAccept = 2'b00; a_s_SData = 16'h0000; a_s_SResp = 4'h0;
    b_m_MCmd = 3'd0; b_m_MAddr = 8'h00; b_m_MData = 8'h00;
    b_s_SCmdAccept = 3'b000; b_s_SData = 24'h000000; b_s_SResp = 6'h00;
    // drive a command during reset: it must be ignored
    a_m_MCmd = 3'd1; a_m_MAddr = 8'hFF; a_m_MData = 8'hFF;
    repeat (2) tick();

    // ---- reset state
    check("rst_a_state",   32'(a_link_state),   32'd0);
    check("rst_a_accept",  32'(a_m_SCmdAccept), 32'd0);
    check("rst_a_smcmd",   32'(a_s_MCmd),       32'd0);
    check("rst_a_saddr",   32'(a_s_MAddr),      32'd0);
    check("rst_a_sresp",   32'(a_m_SResp),      32'd0);
    check("rst_a_errcnt",  32'(a_err_cnt),      32'd0);
    check("rst_b_state",   32'(b_link_state),   32'd0);
    check("rst_b_smcmd",   32'(b_s_MCmd),       32'd0);
    a_m_MCmd = 3'd0; a_m_MAddr = 8'h00; a_m_MData = 8'h00;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
    check("idle_a_state",  32'(a_link_state),   32'd0);

    // ---- T1: WR 0x85/0x3C to slave1, immediate accept
    a_m_MCmd = 3'd1; a_m_MAddr = 8'h85; a_m_MData = 8'h3C; a_s_SCmdAccept = 2'b10;
    tick();
    check("t1_state_req",  32'(a_link_state),   32'd1);
    check("t1_smcmd",      32'(a_s_MCmd),       32'h08);
    check("t1_saddr",      32'(a_s_MAddr),      32'h85);
    check("t1_sdata",      32'(a_s_MData),      32'h3C);
    check("t1_noaccept",   32'(a_m_SCmdAccept), 32'd0);
    check("t1_link",       32'(a_active_link),  32'd1);
    tick();
    check("t1_state_ack",  32'(a_link_state),   32'd2);
    check("t1_accept",     32'(a_m_SCmdAccept), 32'd1);
    check("t1_smcmd_drop", 32'(a_s_MCmd),       32'd0);
    a_m_MCmd = 3'd0; a_s_SCmdAccept = 2'b00;
    tick();
    check("t1_state_idle", 32'(a_link_state),   32'd0);
    check("t1_accept_off", 32'(a_m_SCmdAccept), 32'd0);
    check("t1_sresp",      32'(a_m_SResp),      32'd0);

    // ---- T2: RD 0x10 from slave0, accept after 2 cycles, DVA/0xA5 after 3 more
    a_m_MCmd = 3'd2; a_m_MAddr = 8'h10; a_m_MData = 8'h00;
    tick();
    check("t2_req1",       32'(a_link_state),   32'd1);
    check("t2_smcmd",      32'(a_s_MCmd),       32'h02);
    check("t2_link",       32'(a_active_link),  32'd0);
    tick();
    check("t2_req2",       32'(a_link_state),   32'd1);
    a_s_SCmdAccept = 2'b01;
    tick();
    check("t2_ack",        32'(a_m_SCmdAccept), 32'd1);
    a_m_MCmd = 3'd0; a_s_SCmdAccept = 2'b00;
    // unselected slave1 drives ERR: must be ignored
    a_s_SResp = 4'b1100; a_s_SData = 16'h5A00;
    tick();
    check("t2_resp1",      32'(a_link_state),   32'd3);
    check("t2_resp1_out",  32'(a_m_SResp),      32'd0);
    tick();
    check("t2_resp2",      32'(a_link_state),   32'd3);
    tick();
    check("t2_resp3",      32'(a_link_state),   32'd3);
    a_s_SResp = 4'b1101; a_s_SData = 16'h5AA5;
    tick();
    check("t2_done",       32'(a_link_state),   32'd4);
    check("t2_mresp",      32'(a_m_SResp),      32'd1);
    check("t2_mdata",      32'(a_m_SData),      32'hA5);
    check("t2_errcnt",     32'(a_err_cnt),      32'd0);
    a_s_SResp = 4'b0000; a_s_SData = 16'h0000;
    tick();
    check("t2_idle",       32'(a_link_state),   32'd0);
    check("t2_mresp_off",  32'(a_m_SResp),      32'd0);
    check("t2_mdata_off",  32'(a_m_SData),      32'd0);

    // ---- slave1 returns ERR with data: passed through and counted
    a_m_MCmd = 3'd2; a_m_MAddr = 8'h80; a_s_SCmdAccept = 2'b10;
    tick();
    tick();
    a_m_MCmd = 3'd0; a_s_SCmdAccept = 2'b00;
    a_s_SResp = 4'b1100; a_s_SData = 16'h1100;
    tick();
    tick();
    check("serr_mresp",    32'(a_m_SResp),      32'd3);
    check("serr_mdata",    32'(a_m_SData),      32'h11);
    check("serr_errcnt",   32'(a_err_cnt),      32'd1);
    a_s_SResp = 4'b0000; a_s_SData = 16'h0000;
    tick();

    // ---- T6: reset asserted during RESP, then a normal WR
    a_m_MCmd = 3'd2; a_m_MAddr = 8'h90; a_s_SCmdAccept = 2'b10;
    tick();
    tick();
    a_m_MCmd = 3'd0; a_s_SCmdAccept = 2'b00;
    tick();
    check("t6_in_resp",    32'(a_link_state),   32'd3);
    a_rst_n = 1'b0;
    #1;
    check("t6_state",      32'(a_link_state),   32'd0);
    check("t6_link",       32'(a_active_link),  32'd0);
    check("t6_saddr",      32'(a_s_MAddr),      32'd0);
    check("t6_errcnt",     32'(a_err_cnt),      32'd0);
    check("t6_mresp",      32'(a_m_SResp),      32'd0);
    a_s_SResp = 4'b0100; a_s_SData = 16'h3300;
    tick();
    check("t6_hold_state", 32'(a_link_state),   32'd0);
    check("t6_hold_resp",  32'(a_m_SResp),      32'd0);
    a_rst_n = 1'b1; a_s_SResp = 4'b0000; a_s_SData = 16'h0000;
    a_m_MCmd = 3'd1; a_m_MAddr = 8'h00; a_m_MData = 8'h77; a_s_SCmdAccept = 2'b01;
    tick();
    check("t6_wr_smcmd",   32'(a_s_MCmd),       32'h01);
    check("t6_wr_sdata",   32'(a_s_MData),      32'h77);
    tick();
    check("t6_wr_accept",  32'(a_m_SCmdAccept), 32'd1);
    a_m_MCmd = 3'd0; a_s_SCmdAccept = 2'b00;
    tick();
    check("t6_wr_idle",    32'(a_link_state),   32'd0);

    // ---- B: WR to slave2 (addr 0x80)
    b_m_MCmd = 3'd1; b_m_MAddr = 8'h80; b_m_MData = 8'h5C; b_s_SCmdAccept = 3'b100;
    tick();
    check("b_wr_smcmd",    32'(b_s_MCmd),       32'h040);
    check("b_wr_link",     32'(b_active_link),  32'd2);
    tick();
    check("b_wr_accept",   32'(b_m_SCmdAccept), 32'd1);
    b_m_MCmd = 3'd0; b_s_SCmdAccept = 3'b000;
    tick();
    check("b_wr_idle",     32'(b_link_state),   32'd0);
    check("b_wr_errcnt",   32'(b_err_cnt),      32'd0);

    // ---- T3: RD to slave0 that never accepts, TIMEOUT=4
    b_m_MCmd = 3'd2; b_m_MAddr = 8'h10;
    tick();
    check("t3_smcmd",      32'(b_s_MCmd),       32'h002);
    tick();
    tick();
    tick();
    check("t3_req4",       32'(b_link_state),   32'd1);
    check("t3_req4_acc",   32'(b_m_SCmdAccept), 32'd0);
    tick();
    check("t3_ack",        32'(b_m_SCmdAccept), 32'd1);
    check("t3_smcmd_drop", 32'(b_s_MCmd),       32'd0);
    check("t3_errcnt",     32'(b_err_cnt),      32'd1);
    b_m_MCmd = 3'd0;
    tick();
    check("t3_mresp",      32'(b_m_SResp),      32'd3);
    check("t3_mdata",      32'(b_m_SData),      32'd0);
    tick();
    check("t3_idle",       32'(b_link_state),   32'd0);

    // ---- T4: RD 0xC0 decodes to sel 3 >= NUM_SLAVES
    b_m_MCmd = 3'd2; b_m_MAddr = 8'hC0;
    tick();
    check("t4_ack",        32'(b_link_state),   32'd2);
    check("t4_accept",     32'(b_m_SCmdAccept), 32'd1);
    check("t4_smcmd",      32'(b_s_MCmd),       32'd0);
    check("t4_errcnt",     32'(b_err_cnt),      32'd2);
    check("t4_link_kept",  32'(b_active_link),  32'd0);
    b_m_MCmd = 3'd0;
    tick();
    check("t4_mresp",      32'(b_m_SResp),      32'd3);
    tick();

    // ---- RESP timeout: slave1 accepts but never responds
    b_m_MCmd = 3'd2; b_m_MAddr = 8'h40; b_s_SCmdAccept = 3'b010;
    tick();
    tick();
    b_m_MCmd = 3'd0; b_s_SCmdAccept = 3'b000;
    tick();
    tick();
    tick();
    tick();
    check("rto_resp4",     32'(b_link_state),   32'd3);
    tick();
    check("rto_mresp",     32'(b_m_SResp),      32'd3);
    check("rto_mdata",     32'(b_m_SData),      32'd0);
    check("rto_errcnt",    32'(b_err_cnt),      32'd3);
    tick();

    // ---- T5: 300 REQ timeouts saturate err_cnt
    for (int i = 0; i < 300; i++) begin
      b_m_MCmd = 3'd2; b_m_MAddr = 8'h10;
      repeat (5) tick();
      b_m_MCmd = 3'd0;
      tick();
      if (i == 299) check("t5_last_mresp", 32'(b_m_SResp), 32'd3);
      tick();
    end
    check("t5_errcnt_sat", 32'(b_err_cnt),      32'd255);
    check("t5_idle",       32'(b_link_state),   32'd0);
    b_m_MCmd = 3'd2; b_m_MAddr = 8'h40; b_s_SCmdAccept = 3'b010;
    b_s_SResp = 6'b000100; b_s_SData = 24'h003E00;
    tick();
    tick();
    b_m_MCmd = 3'd0; b_s_SCmdAccept = 3'b000;
    tick();
    tick();
    check("t5_rd_mresp",   32'(b_m_SResp),      32'd1);
    check("t5_rd_mdata",   32'(b_m_SData),      32'h3E);
    check("t5_rd_link",    32'(b_active_link),  32'd1);
    check("t5_rd_errcnt",  32'(b_err_cnt),      32'd255);
    b_s_SResp = 6'b000000; b_s_SData = 24'h000000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
